instr_queue: RTL and testbench

Parametrised instruction register for the multicycle MIPS datapath: a DEPTH-entry prefetch queue between instruction memory and the control/decode stage, replacing the single-entry IRwrite-latched register. Memory pushes fetched words tagged with their PC. Decode pops them under a valid/ready handshake. The head entry is presented as split MIPS fields (opcode, funct, rs, rt, rd, shamt, immediate, addr26), and a synchronous flush discards prefetched words on branch/jump redirect.

---
 rtl/ir_pkg.sv | 38 +++
 rtl/ir_field_decode.sv | 25 ++
 rtl/instr_queue.sv | 129 ++++++++++++
 tb/tb_instr_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared MIPS instruction-field layout for the prefetch queue and its field decoder.
// Field bit positions, the decoded-field struct and a helper that zeroes it.
package ir_pkg;

    localparam int OPC_HI    = 31;
    localparam int OPC_LO    = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int SHAMT_HI  = 10;
    localparam int SHAMT_LO  = 6;
    localparam int FUNCT_HI  = 5;
    localparam int FUNCT_LO  = 0;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int ADDR26_HI = 25;
    localparam int ADDR26_LO = 0;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] immediate;
        logic [25:0] addr26;
    } ir_fields_t;

    // Zero every field unless the word behind it is valid.
    function automatic ir_fields_t ir_mask(input ir_fields_t f, input logic valid);
        return valid ? f : '0;
    endfunction

endpackage

// File: rtl/ir_field_decode.sv
// Splits a 32-bit MIPS word into its fields; all fields read 0 when the word is not valid.
module ir_field_decode
    import ir_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic        valid_i,
    output ir_fields_t  fields_o
);

    ir_fields_t raw;

    always_comb begin
        raw           = '0;
        raw.opcode    = word_i[OPC_HI:OPC_LO];
        raw.rs        = word_i[RS_HI:RS_LO];
        raw.rt        = word_i[RT_HI:RT_LO];
        raw.rd        = word_i[RD_HI:RD_LO];
        raw.shamt     = word_i[SHAMT_HI:SHAMT_LO];
        raw.funct     = word_i[FUNCT_HI:FUNCT_LO];
        raw.immediate = word_i[IMM_HI:IMM_LO];
        raw.addr26    = word_i[ADDR26_HI:ADDR26_LO];
        fields_o      = ir_mask(raw, valid_i);
    end

endmodule

// File: rtl/instr_queue.sv
// DEPTH-entry instruction prefetch queue between instruction memory and decode.
// Optional same-cycle empty-queue bypass enabled by defining IQ_BYPASS_EN.
module instr_queue
    import ir_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [31:0]                memdata,
    input  logic [PC_W-1:0]            mem_pc,
    input  logic                       flush,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [5:0]                 opcode,
    output logic [5:0]                 funct,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [4:0]                 shamt,
    output logic [15:0]                immediate,
    output logic [25:0]                addr26,
    output logic [PC_W-1:0]            head_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]     word_q [DEPTH];
    logic [PC_W-1:0] pc_q   [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic            empty, full, bypass, push, pop;
    logic [31:0]     head_word;
    logic [PC_W-1:0] head_pc_raw;
    ir_fields_t      fields;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign mem_ready = !full && !flush;

`ifdef IQ_BYPASS_EN
    assign bypass = empty && !flush && mem_valid;
`else
    assign bypass = 1'b0;
`endif

    assign dec_valid = (!empty || bypass) && !flush;
    // A bypassed word taken by decode in the same cycle never enters storage.
    assign push      = mem_valid && mem_ready && !(bypass && dec_ready);
    assign pop       = dec_valid && dec_ready && !bypass;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately unreset; outputs are masked by dec_valid instead.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wptr_q == PTR_W'(gi))) begin
                word_q[gi] <= memdata;
                pc_q[gi]   <= mem_pc;
            end
        end
    end

    always_comb begin
        head_word   = word_q[rptr_q];
        head_pc_raw = pc_q[rptr_q];
`ifdef IQ_BYPASS_EN
        if (bypass) begin
            head_word   = memdata;
            head_pc_raw = mem_pc;
        end
`endif
    end

    ir_field_decode u_decode (
        .word_i   (head_word),
        .valid_i  (dec_valid),
        .fields_o (fields)
    );

    assign opcode    = fields.opcode;
    assign funct     = fields.funct;
    assign rs        = fields.rs;
    assign rt        = fields.rt;
    assign rd        = fields.rd;
    assign shamt     = fields.shamt;
    assign immediate = fields.immediate;
    assign addr26    = fields.addr26;
    assign head_pc   = dec_valid ? head_pc_raw : '0;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue; bypass checks are included when IQ_BYPASS_EN is defined.
module tb_instr_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mem_valid = 1'b0;
    logic             mem_ready;
    logic [31:0]      memdata = '0;
    logic [PC_W-1:0]  mem_pc = '0;
    logic             flush = 1'b0;
    logic             dec_valid;
    logic             dec_ready = 1'b0;
    logic [5:0]       opcode, funct;
    logic [4:0]       rs, rt, rd, shamt;
    logic [15:0]      immediate;
    logic [25:0]      addr26;
    logic [PC_W-1:0]  head_pc;
    logic [CNT_W-1:0] count;

    typedef struct packed {
        logic [31:0]     word;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    bit     exp_dv;
    logic [PC_W-1:0] pc_gen = 32'h1000;

    instr_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .memdata   (memdata),
        .mem_pc    (mem_pc),
        .flush     (flush),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready),
        .opcode    (opcode),
        .funct     (funct),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .immediate (immediate),
        .addr26    (addr26),
        .head_pc   (head_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_dec_valid"}, 64'(dec_valid), 64'd0);
        check({tag, "_mem_ready"}, 64'(mem_ready), 64'd1);
        check({tag, "_zero"}, 64'(|{opcode, rs, rt, rd, shamt, funct, immediate, addr26, head_pc}), 64'd0);
    endtask

    // Apply inputs just after an edge, then compare settled outputs against the model.
    task automatic drive(input logic mv, input logic [31:0] w, input logic [PC_W-1:0] pc,
                         input logic dr, input logic fl);
        entry_t head;
        mem_valid = mv;
        memdata   = w;
        mem_pc    = pc;
        dec_ready = dr;
        flush     = fl;
        #2;
        exp_dv = !fl && ((sb.size() != 0) || (BYP && mv));
        check("count", 64'(count), 64'(sb.size()));
        check("mem_ready", 64'(mem_ready), 64'(!fl && (sb.size() != DEPTH)));
        check("dec_valid", 64'(dec_valid), 64'(exp_dv));
        if (exp_dv) begin
            head = (sb.size() != 0) ? sb[0] : entry_t'({w, pc});
            check("fields", 64'({opcode, rs, rt, rd, shamt, funct}), 64'(head.word));
            check("immediate", 64'(immediate), 64'(head.word[15:0]));
            check("addr26", 64'(addr26), 64'(head.word[25:0]));
            check("head_pc", 64'(head_pc), 64'(head.pc));
        end else begin
            check("idle_zero", 64'(|{opcode, rs, rt, rd, shamt, funct, immediate, addr26, head_pc}), 64'd0);
        end
    endtask

    // Advance the model with the transfers implied by the sampled inputs, then clock.
    task automatic commit();
        bit     do_pop;
        bit     do_push;
        entry_t e;
        if (flush) begin
            $display("flush  dropped=%0d", sb.size());
            sb.delete();
        end else begin
            do_pop  = exp_dv && dec_ready;
            do_push = mem_valid && (sb.size() != DEPTH);
            if (do_pop && sb.size() == 0) begin
                $display("bypass word=%08h pc=%08h", memdata, mem_pc);
            end else begin
                if (do_pop) begin
                    e = sb.pop_front();
                    $display("pop    word=%08h pc=%08h", e.word, e.pc);
                end
                if (do_push) begin
                    sb.push_back({memdata, mem_pc});
                    $display("push   word=%08h pc=%08h", memdata, mem_pc);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        drive(1'b1, w, pc_gen, 1'b0, 1'b0);
        commit();
        pc_gen = pc_gen + 32'd4;
    endtask

    task automatic pop_word();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        commit();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // lw $2,4($1) at pc 0x100, held by decode
        drive(1'b1, 32'h8C220004, 32'h100, 1'b0, 1'b0);
        commit();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("t1_opcode", 64'(opcode), 64'h23);
        check("t1_rs", 64'(rs), 64'd1);
        check("t1_rt", 64'(rt), 64'd2);
        check("t1_imm", 64'(immediate), 64'h4);
        check("t1_head_pc", 64'(head_pc), 64'h100);
        check("t1_count", 64'(count), 64'd1);
        commit();
        pop_word();

        // Fill, refuse an extra word, then drain; three rounds wrap both pointers.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) push_word($urandom);
            drive(1'b1, 32'hFFFF0000, 32'hDEAD, 1'b1, 1'b0);
            check("full_mem_ready", 64'(mem_ready), 64'd0);
            commit();
            check("full_count", 64'(count), 64'(DEPTH - 1));
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            commit();
            push_word($urandom);
            check("refill_count", 64'(count), 64'(DEPTH));
            for (int i = 0; i < DEPTH; i++) pop_word();
        end

        // Simultaneous push and pop with two entries queued
        push_word(32'h20080001);
        push_word(32'h20090002);
        drive(1'b1, 32'h200A0003, pc_gen, 1'b1, 1'b0);
        check("pp_head_oldest", 64'(immediate), 64'h1);
        commit();
        pc_gen = pc_gen + 32'd4;
        check("pp_count", 64'(count), 64'd2);
        pop_word();
        pop_word();

        // Flush wins over a same-cycle push and pop
        drive(1'b1, 32'h012A4020, 32'h200, 1'b0, 1'b0);
        commit();
        drive(1'b1, 32'hDEADBEEF, 32'h204, 1'b1, 1'b1);
        commit();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_idle_outputs("flush");
        commit();

`ifdef IQ_BYPASS_EN
        // j 0x100 into an empty queue with decode ready
        drive(1'b1, 32'h08000040, 32'h300, 1'b1, 1'b0);
        check("byp_dec_valid", 64'(dec_valid), 64'd1);
        check("byp_opcode", 64'(opcode), 64'h02);
        check("byp_addr26", 64'(addr26), 64'h40);
        commit();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("byp_count", 64'(count), 64'd0);
        commit();
`endif

        // Asynchronous reset between edges with three entries queued
        push_word(32'h11111111);
        push_word(32'h22222222);
        push_word(32'h33333333);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("pre_rst_count", 64'(count), 64'd3);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, pc_gen, 1'($urandom_range(0, 1)), 1'b0);
            commit();
            pc_gen = pc_gen + 32'd4;
        end
        while (sb.size() != 0) pop_word();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        commit();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
